// File: rtl/apb_req_arbiter_if.sv
// Bundle of requester-side and APB-master-side signals for apb_req_arbiter.
// The slave modport is the arbiter's view: it serves the requesters and
// drives the master-interface request. The master modport is the view of
// whoever sits around the arbiter (requesters plus APB master agent).
interface apb_req_arbiter_if #(
   parameter int REQ_NUM        = 4,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32
);
   localparam int IDX_W = $clog2(REQ_NUM);

   logic [REQ_NUM-1:0]                req_sel_in;
   logic [REQ_NUM*APB_ADDR_WIDTH-1:0] req_addr_in;
   logic [REQ_NUM*APB_DATA_WIDTH-1:0] req_wdata_in;
   logic [REQ_NUM-1:0]                req_write_in;
   logic [REQ_NUM-1:0]                req_ready_out;
   logic                              req_error_out;
   logic [APB_DATA_WIDTH-1:0]         req_rdata_out;
   logic                              mst_sel_out;
   logic [APB_ADDR_WIDTH-1:0]         mst_addr_out;
   logic [APB_DATA_WIDTH-1:0]         mst_wdata_out;
   logic                              mst_write_out;
   logic                              mst_ready_in;
   logic                              mst_error_in;
   logic [APB_DATA_WIDTH-1:0]         mst_rdata_in;
   logic                              grant_valid_out;
   logic [IDX_W-1:0]                  grant_idx_out;

   modport master (
      output req_sel_in, req_addr_in, req_wdata_in, req_write_in,
             mst_ready_in, mst_error_in, mst_rdata_in,
      input  req_ready_out, req_error_out, req_rdata_out,
             mst_sel_out, mst_addr_out, mst_wdata_out, mst_write_out,
             grant_valid_out, grant_idx_out
   );

   modport slave (
      input  req_sel_in, req_addr_in, req_wdata_in, req_write_in,
             mst_ready_in, mst_error_in, mst_rdata_in,
      output req_ready_out, req_error_out, req_rdata_out,
             mst_sel_out, mst_addr_out, mst_wdata_out, mst_write_out,
             grant_valid_out, grant_idx_out
   );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that funnels REQ_NUM requesters onto one APB master
// interface. A transfer is granted in IDLE, runs in BUSY until the master
// completes, the requester withdraws or the watchdog expires, optionally
// drains in DRAIN, and always spends one DONE cycle before re-arbitrating.
module apb_req_arbiter #(
   parameter int REQ_NUM        = 4,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int WATCHDOG_CYCLE = 16
) (
   input logic             apb_clk_in,
   input logic             apb_rstn_in,
   apb_req_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(REQ_NUM);
   localparam int WD_W  = $clog2(WATCHDOG_CYCLE + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]                state;
   logic [IDX_W-1:0]          last_ptr;
   logic [WD_W-1:0]           wd_cnt;
   logic [WD_W-1:0]           wd_next;
   logic                      wd_hit;

   logic [REQ_NUM-1:0]        ready_q;
   logic                      error_q;
   logic [APB_DATA_WIDTH-1:0] rdata_q;
   logic                      sel_q;
   logic [APB_ADDR_WIDTH-1:0] addr_q;
   logic [APB_DATA_WIDTH-1:0] wdata_q;
   logic                      write_q;
   logic                      grant_valid_q;
   logic [IDX_W-1:0]          grant_idx_q;

   logic [APB_ADDR_WIDTH-1:0] addr_arr  [REQ_NUM];
   logic [APB_DATA_WIDTH-1:0] wdata_arr [REQ_NUM];
   logic                      win_found;
   logic [IDX_W-1:0]          win_idx;
   logic [IDX_W-1:0]          cand;

   // Unpack the flat requester buses into per-requester slices.
   for (genvar g = 0; g < REQ_NUM; g++) begin : g_unpack
      assign addr_arr[g]  = bus.req_addr_in[g*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
      assign wdata_arr[g] = bus.req_wdata_in[g*APB_DATA_WIDTH +: APB_DATA_WIDTH];
   end

   assign wd_next = wd_cnt + 1'b1;
   assign wd_hit  = (wd_next == WD_W'(WATCHDOG_CYCLE));

   // Round-robin search starting just after the last served requester.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         cand = IDX_W'((int'(last_ptr) + 1 + k) % REQ_NUM);
         if (!win_found && bus.req_sel_in[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Transfer state machine; responses default low so every pulse is one cycle.
   always_ff @(posedge apb_clk_in) begin
      if (!apb_rstn_in) begin
         state         <= ST_IDLE;
         last_ptr      <= IDX_W'(REQ_NUM - 1);
         wd_cnt        <= '0;
         ready_q       <= '0;
         error_q       <= 1'b0;
         rdata_q       <= '0;
         sel_q         <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         write_q       <= 1'b0;
         grant_valid_q <= 1'b0;
         grant_idx_q   <= '0;
      end else begin
         ready_q <= '0;
         error_q <= 1'b0;
         rdata_q <= '0;
         case (state)
            ST_IDLE: begin
               if (win_found) begin
                  addr_q        <= addr_arr[win_idx];
                  write_q       <= bus.req_write_in[win_idx];
                  wdata_q       <= bus.req_write_in[win_idx] ? wdata_arr[win_idx] : '0;
                  sel_q         <= 1'b1;
                  grant_valid_q <= 1'b1;
                  grant_idx_q   <= win_idx;
                  wd_cnt        <= '0;
                  state         <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (bus.mst_ready_in) begin
                  ready_q[grant_idx_q] <= 1'b1;
                  rdata_q              <= write_q ? '0 : bus.mst_rdata_in;
                  error_q              <= bus.mst_error_in;
                  sel_q                <= 1'b0;
                  grant_valid_q        <= 1'b0;
                  last_ptr             <= grant_idx_q;
                  state                <= ST_DONE;
               end else if (!bus.req_sel_in[grant_idx_q]) begin
                  sel_q  <= 1'b0;
                  wd_cnt <= '0;
                  state  <= ST_DRAIN;
               end else if (wd_hit) begin
                  ready_q[grant_idx_q] <= 1'b1;
                  error_q              <= 1'b1;
                  sel_q                <= 1'b0;
                  last_ptr             <= grant_idx_q;
                  wd_cnt               <= '0;
                  state                <= ST_DRAIN;
               end else begin
                  wd_cnt <= wd_next;
               end
            end
            ST_DRAIN: begin
               if (bus.mst_ready_in || wd_hit) begin
                  grant_valid_q <= 1'b0;
                  wd_cnt        <= '0;
                  state         <= ST_DONE;
               end else begin
                  wd_cnt <= wd_next;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready_out   = ready_q;
   assign bus.req_error_out   = error_q;
   assign bus.req_rdata_out   = rdata_q;
   assign bus.mst_sel_out     = sel_q;
   assign bus.mst_addr_out    = addr_q;
   assign bus.mst_wdata_out   = wdata_q;
   assign bus.mst_write_out   = write_q;
   assign bus.grant_valid_out = grant_valid_q;
   assign bus.grant_idx_out   = grant_idx_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: one clock per vector, outputs checked
// 1 ns after the rising edge against hand-computed expectations.
module tb_apb_req_arbiter;
   typedef struct {
      logic [3:0]  ready;
      logic        err;
      logic [31:0] rdata;
      logic        sel;
      logic        gv;
      logic [1:0]  idx;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
   } exp_t;

   typedef struct {
      string       name;
      logic        rstn;
      logic [3:0]  sel;
      logic [3:0]  wr;
      logic        rdy;
      logic        err;
      logic [31:0] rdata;
      exp_t        exp;
   } vec_t;

   logic apb_clk_in;
   logic apb_rstn_in;
   int   applied;
   int   miscompares;
   vec_t tbl[$];

   apb_req_arbiter_if #(.REQ_NUM(4), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) bus ();

   apb_req_arbiter #(
      .REQ_NUM(4), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .WATCHDOG_CYCLE(16)
   ) dut (
      .apb_clk_in (apb_clk_in),
      .apb_rstn_in(apb_rstn_in),
      .bus        (bus)
   );

   // Free-running 100 MHz clock.
   initial apb_clk_in = 1'b0;
   always #5 apb_clk_in = ~apb_clk_in;

   function automatic logic [31:0] addrOf(int g);
      return 32'h100 * (g + 1);
   endfunction

   function automatic logic [31:0] wdataOf(int g);
      return 32'h1111_1111 * (g + 1);
   endfunction

   function automatic exp_t eZero();
      exp_t e;
      e = '{ready: 4'b0, err: 1'b0, rdata: 32'h0, sel: 1'b0, gv: 1'b0,
            idx: 2'd0, addr: 32'h0, wr: 1'b0, wdata: 32'h0};
      return e;
   endfunction

   function automatic exp_t eHold(int g, logic s, logic v);
      exp_t e;
      e = eZero();
      e.sel  = s;
      e.gv   = v;
      e.idx  = 2'(g);
      e.addr = addrOf(g);
      return e;
   endfunction

   function automatic exp_t eResp(int g, logic [3:0] r, logic er, logic [31:0] rd, logic v);
      exp_t e;
      e = eHold(g, 1'b0, v);
      e.ready = r;
      e.err   = er;
      e.rdata = rd;
      return e;
   endfunction

   function automatic vec_t mk(string nm, logic rs, logic [3:0] s, logic [3:0] w,
                               logic rdy, logic er, logic [31:0] rd, exp_t e);
      vec_t v;
      v = '{name: nm, rstn: rs, sel: s, wr: w, rdy: rdy, err: er, rdata: rd, exp: e};
      return v;
   endfunction

   task automatic checkOutput(input vec_t v);
      applied++;
      if (bus.req_ready_out !== v.exp.ready || bus.req_error_out !== v.exp.err ||
          bus.req_rdata_out !== v.exp.rdata || bus.mst_sel_out !== v.exp.sel ||
          bus.grant_valid_out !== v.exp.gv || bus.grant_idx_out !== v.exp.idx ||
          bus.mst_addr_out !== v.exp.addr || bus.mst_write_out !== v.exp.wr ||
          bus.mst_wdata_out !== v.exp.wdata) begin
         miscompares++;
         $display("[TB] FAIL %s: got ready=%b err=%b rdata=%h sel=%b gv=%b idx=%0d addr=%h wr=%b wdata=%h | expected ready=%b err=%b rdata=%h sel=%b gv=%b idx=%0d addr=%h wr=%b wdata=%h",
                  v.name, bus.req_ready_out, bus.req_error_out, bus.req_rdata_out,
                  bus.mst_sel_out, bus.grant_valid_out, bus.grant_idx_out,
                  bus.mst_addr_out, bus.mst_write_out, bus.mst_wdata_out,
                  v.exp.ready, v.exp.err, v.exp.rdata, v.exp.sel, v.exp.gv,
                  v.exp.idx, v.exp.addr, v.exp.wr, v.exp.wdata);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      apb_rstn_in      = v.rstn;
      bus.req_sel_in   = v.sel;
      bus.req_write_in = v.wr;
      bus.mst_ready_in = v.rdy;
      bus.mst_error_in = v.err;
      bus.mst_rdata_in = v.rdata;
      @(posedge apb_clk_in);
      #1;
      checkOutput(v);
   endtask

   // Build the vector table, run it, then the hand-written corner sequences.
   initial begin
      exp_t e;
      logic [31:0] rd;
      applied     = 0;
      miscompares = 0;
      apb_rstn_in = 1'b0;
      bus.req_sel_in   = '0;
      bus.req_write_in = '0;
      bus.mst_ready_in = 1'b0;
      bus.mst_error_in = 1'b0;
      bus.mst_rdata_in = '0;
      for (int i = 0; i < 4; i++) begin
         bus.req_addr_in[i*32 +: 32]  = addrOf(i);
         bus.req_wdata_in[i*32 +: 32] = wdataOf(i);
      end
      #2;

      tbl.push_back(mk("reset0", 0, 4'b0000, 4'b0, 0, 0, 0, eZero()));
      tbl.push_back(mk("reset1", 0, 4'b0000, 4'b0, 0, 0, 0, eZero()));
      tbl.push_back(mk("rd_grant", 1, 4'b0001, 4'b0, 0, 0, 0, eHold(0, 1, 1)));
      tbl.push_back(mk("rd_wait1", 1, 4'b0001, 4'b0, 0, 0, 0, eHold(0, 1, 1)));
      tbl.push_back(mk("rd_wait2", 1, 4'b0001, 4'b0, 0, 0, 0, eHold(0, 1, 1)));
      tbl.push_back(mk("rd_cmp", 1, 4'b0001, 4'b0, 1, 0, 32'hDEAD_BEEF,
                       eResp(0, 4'b0001, 0, 32'hDEAD_BEEF, 0)));
      tbl.push_back(mk("rd_done", 1, 4'b0000, 4'b0, 0, 0, 0, eHold(0, 0, 0)));
      tbl.push_back(mk("rd_idle", 1, 4'b0000, 4'b0, 0, 0, 0, eHold(0, 0, 0)));
      tbl.push_back(mk("reset2", 0, 4'b1111, 4'b0, 0, 0, 0, eZero()));
      for (int t = 0; t < 5; t++) begin
         rd = 32'hC0DE_0000 | 32'(t % 4);
         tbl.push_back(mk($sformatf("rr%0d_grant", t), 1, 4'b1111, 4'b0, 0, 0, 0,
                          eHold(t % 4, 1, 1)));
         tbl.push_back(mk($sformatf("rr%0d_cmp", t), 1, 4'b1111, 4'b0, 1, 0, rd,
                          eResp(t % 4, 4'(1 << (t % 4)), 0, rd, 0)));
         tbl.push_back(mk($sformatf("rr%0d_done", t), 1, 4'b1111, 4'b0, 0, 0, 0,
                          eHold(t % 4, 0, 0)));
      end
      tbl.push_back(mk("rr_idle", 1, 4'b0000, 4'b0, 0, 0, 0, eHold(0, 0, 0)));
      tbl.push_back(mk("wd_grant", 1, 4'b0100, 4'b0, 0, 0, 0, eHold(2, 1, 1)));
      for (int c = 1; c <= 15; c++)
         tbl.push_back(mk($sformatf("wd_busy%0d", c), 1, 4'b0100, 4'b0, 0, 0, 0,
                          eHold(2, 1, 1)));
      tbl.push_back(mk("wd_abort", 1, 4'b0100, 4'b0, 0, 0, 0, eResp(2, 4'b0100, 1, 0, 1)));
      tbl.push_back(mk("wd_drain1", 1, 4'b0000, 4'b0, 0, 0, 0, eHold(2, 0, 1)));
      tbl.push_back(mk("wd_drain_end", 1, 4'b0000, 4'b0, 1, 1, 32'h7777_7777, eHold(2, 0, 0)));
      tbl.push_back(mk("wd_done", 1, 4'b0000, 4'b0, 0, 0, 0, eHold(2, 0, 0)));

      foreach (tbl[i]) applyStimulus(tbl[i]);

      // Write transfer on requester 1 with requester inputs changing in BUSY.
      e = eHold(1, 1, 1);
      e.wr    = 1'b1;
      e.wdata = wdataOf(1);
      applyStimulus(mk("wr_grant", 1, 4'b0010, 4'b0010, 0, 0, 0, e));
      bus.req_addr_in[32 +: 32]  = 32'h0000_BAD0;
      bus.req_wdata_in[32 +: 32] = 32'hFFFF_FFFF;
      applyStimulus(mk("wr_stable", 1, 4'b0010, 4'b0000, 0, 0, 0, e));
      e.sel   = 1'b0;
      e.gv    = 1'b0;
      e.ready = 4'b0010;
      e.err   = 1'b1;
      applyStimulus(mk("wr_cmp_err", 1, 4'b0010, 4'b0000, 1, 1, 32'h1234_5678, e));
      e.ready = 4'b0000;
      e.err   = 1'b0;
      applyStimulus(mk("wr_done", 1, 4'b0000, 4'b0000, 0, 0, 0, e));
      bus.req_addr_in[32 +: 32]  = addrOf(1);
      bus.req_wdata_in[32 +: 32] = wdataOf(1);

      // Requester 2 withdraws; the pointer must stay at 1 afterwards.
      applyStimulus(mk("wdr_grant", 1, 4'b0100, 4'b0, 0, 0, 0, eHold(2, 1, 1)));
      applyStimulus(mk("wdr_busy", 1, 4'b0100, 4'b0, 0, 0, 0, eHold(2, 1, 1)));
      applyStimulus(mk("wdr_drop", 1, 4'b0000, 4'b0, 0, 0, 0, eHold(2, 0, 1)));
      applyStimulus(mk("wdr_drain_end", 1, 4'b0000, 4'b0, 1, 0, 32'h9999_9999, eHold(2, 0, 0)));
      applyStimulus(mk("wdr_done", 1, 4'b0000, 4'b0, 0, 0, 0, eHold(2, 0, 0)));
      applyStimulus(mk("wdr_ptr_probe", 1, 4'b0101, 4'b0, 0, 0, 0, eHold(2, 1, 1)));

      // Reset in BUSY, then lowest requesting index wins.
      applyStimulus(mk("rst_busy", 0, 4'b0101, 4'b0, 0, 0, 0, eZero()));
      applyStimulus(mk("rst_regrant", 1, 4'b1010, 4'b0, 0, 0, 0, eHold(1, 1, 1)));

      // Ready together with withdrawal completes normally.
      applyStimulus(mk("rdy_wdr", 1, 4'b0000, 4'b0, 1, 0, 32'h5555_AAAA,
                       eResp(1, 4'b0010, 0, 32'h5555_AAAA, 0)));
      applyStimulus(mk("rdy_wdr_done", 1, 4'b0000, 4'b0, 0, 0, 0, eHold(1, 0, 0)));

      // Ready on the watchdog-expiry cycle completes normally.
      applyStimulus(mk("rdy_wd_grant", 1, 4'b0001, 4'b0, 0, 0, 0, eHold(0, 1, 1)));
      for (int c = 1; c <= 15; c++)
         applyStimulus(mk($sformatf("rdy_wd_busy%0d", c), 1, 4'b0001, 4'b0, 0, 0, 0,
                          eHold(0, 1, 1)));
      applyStimulus(mk("rdy_wd_cmp", 1, 4'b0001, 4'b0, 1, 0, 32'h0BAD_F00D,
                       eResp(0, 4'b0001, 0, 32'h0BAD_F00D, 0)));
      applyStimulus(mk("rdy_wd_done", 1, 4'b0000, 4'b0, 0, 0, 0, eHold(0, 0, 0)));

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule
